// File: rtl/zbus_host.sv
// ZX-bus initiator: runs one Z80-timed memory or I/O bus cycle per accepted request.
// Outputs are registered; strobes and data enable are derived from the state being entered.
module zbus_host #(
  parameter int TDIV    = 4,
  parameter int MAXWAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_io,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        claimed,
  output logic        timeout,
  output logic [15:0] za,
  output logic [7:0]  zd_out,
  output logic        zd_oe,
  input  logic [7:0]  zd_in,
  output logic        zmreq_n,
  output logic        ziorq_n,
  output logic        zrd_n,
  output logic        zwr_n,
  input  logic        zwait_n,
  input  logic        ziorqge
);
  localparam int TCW = $clog2(TDIV);
  localparam int WCW = $clog2(MAXWAIT + 1);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TWA, S_TW, S_T3, S_END} state_t;

  state_t         state, state_nxt;
  logic [TCW-1:0] tcnt, tcnt_nxt;
  logic [WCW-1:0] wcnt, wcnt_nxt;
  logic           io_q, wr_q, io_nxt, wr_nxt;
  logic           claim_acc;
  logic           end_to;
  logic           last;
  logic           strobe_on, act;

  assign last = (tcnt == TCW'(TDIV - 1));

  always_comb begin
    state_nxt = state;
    tcnt_nxt  = last ? '0 : tcnt + 1'b1;
    wcnt_nxt  = wcnt;
    io_nxt    = io_q;
    wr_nxt    = wr_q;
    end_to    = 1'b0;
    case (state)
      S_IDLE: begin
        tcnt_nxt = '0;
        if (req) begin
          state_nxt = S_T1;
          io_nxt    = req_io;
          wr_nxt    = req_wr;
        end
      end
      S_T1: if (last) state_nxt = S_T2;
      S_T2: if (last) begin
        if (io_q)         state_nxt = S_TWA;
        else if (zwait_n) state_nxt = S_T3;
        else begin
          state_nxt = S_TW;
          wcnt_nxt  = WCW'(1);
        end
      end
      S_TWA: if (last) begin
        if (zwait_n) state_nxt = S_T3;
        else begin
          state_nxt = S_TW;
          wcnt_nxt  = WCW'(1);
        end
      end
      // Give up once MAXWAIT wait states have all seen zwait_n low.
      S_TW: if (last) begin
        if (zwait_n) state_nxt = S_T3;
        else if (wcnt == WCW'(MAXWAIT)) begin
          state_nxt = S_END;
          end_to    = 1'b1;
        end else wcnt_nxt = wcnt + 1'b1;
      end
      S_T3: if (last) state_nxt = S_END;
      S_END: begin
        state_nxt = S_IDLE;
        tcnt_nxt  = '0;
      end
      default: state_nxt = S_IDLE;
    endcase
    strobe_on = (state_nxt == S_T2) || (state_nxt == S_TWA) ||
                (state_nxt == S_TW) || (state_nxt == S_T3);
    act       = strobe_on || (state_nxt == S_T1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tcnt      <= '0;
      wcnt      <= '0;
      io_q      <= 1'b0;
      wr_q      <= 1'b0;
      claim_acc <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= 8'hFF;
      claimed   <= 1'b0;
      timeout   <= 1'b0;
      za        <= '0;
      zd_out    <= '0;
      zd_oe     <= 1'b0;
      zmreq_n   <= 1'b1;
      ziorq_n   <= 1'b1;
      zrd_n     <= 1'b1;
      zwr_n     <= 1'b1;
    end else begin
      state   <= state_nxt;
      tcnt    <= tcnt_nxt;
      wcnt    <= wcnt_nxt;
      io_q    <= io_nxt;
      wr_q    <= wr_nxt;
      busy    <= (state_nxt != S_IDLE);
      done    <= (state_nxt == S_END);
      zmreq_n <= !(strobe_on && !io_nxt);
      ziorq_n <= !(strobe_on && io_nxt);
      zrd_n   <= !(strobe_on && !wr_nxt);
      zwr_n   <= !(strobe_on && wr_nxt);
      zd_oe   <= act && wr_nxt;
      if (state == S_IDLE && req) begin
        za        <= req_addr;
        claim_acc <= 1'b0;
        if (req_wr) zd_out <= req_wdata;
      end else if (state == S_T2 || state == S_TWA || state == S_TW || state == S_T3) begin
        claim_acc <= claim_acc | ziorqge;
      end
      // Result fields change together with the done pulse and hold until the next one.
      if (state_nxt == S_END) begin
        timeout <= end_to;
        claimed <= io_q && (claim_acc || ziorqge);
        if (end_to)     rdata <= 8'hFF;
        else if (!wr_q) rdata <= zd_in;
      end
    end
  end
endmodule

// File: tb/tb_zbus_host.sv
// Scoreboard bench for zbus_host: expected cycle results queued at request, checked at done.
module tb_zbus_host;
  localparam int TDIV    = 4;
  localparam int MAXWAIT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, req_io = 1'b0, req_wr = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        busy, done, claimed, timeout, zd_oe;
  logic [7:0]  rdata, zd_out;
  logic [15:0] za;
  logic [7:0]  zd_in = 8'h00;
  logic        zmreq_n, ziorq_n, zrd_n, zwr_n;
  logic        zwait_n = 1'b1;
  logic        ziorqge = 1'b0;

  zbus_host #(.TDIV(TDIV), .MAXWAIT(MAXWAIT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_io(req_io), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .done(done),
    .rdata(rdata), .claimed(claimed), .timeout(timeout), .za(za),
    .zd_out(zd_out), .zd_oe(zd_oe), .zd_in(zd_in), .zmreq_n(zmreq_n),
    .ziorq_n(ziorq_n), .zrd_n(zrd_n), .zwr_n(zwr_n), .zwait_n(zwait_n),
    .ziorqge(ziorqge)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        claimed;
    logic        timeout;
    int          lat;
    int          slow;
    int          oe;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nmis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: per-cycle latency, strobe and drive-enable counts, compared at done.
  logic prev_busy = 1'b0;
  int   lat = 0, slow = 0, oecnt = 0;
  logic rwbad = 1'b0;
  always @(negedge clk) begin
    if (busy && !prev_busy) begin
      lat = 1; slow = 0; oecnt = 0; rwbad = 1'b0;
    end else if (busy) lat++;
    if (busy) begin
      if (!zmreq_n || !ziorq_n) slow++;
      if (zd_oe) oecnt++;
      if (!zrd_n && !zwr_n) rwbad = 1'b1;
    end
    if (done) begin
      if (sb.size() == 0) chk("spurious_done", 32'(done), 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency", lat, e.lat);
        chk("strobe_clks", slow, e.slow);
        chk("oe_clks", oecnt, e.oe);
        chk("rd_wr_both_low", 32'(rwbad), 32'd0);
        chk("end_strobes", {zmreq_n, ziorq_n, zrd_n, zwr_n, zd_oe}, 5'b11110);
        chk("za", za, e.addr);
        chk("claimed", 32'(claimed), 32'(e.claimed));
        chk("timeout", 32'(timeout), 32'(e.timeout));
        if (e.wr) chk("zd_out", zd_out, e.wdata);
        else      chk("rdata", rdata, e.rdata);
      end
    end
    prev_busy = busy;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (busy) chk("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    if (!done) chk("done_wait", 32'(done), 32'd1);
  endtask

  function automatic exp_t mk(input logic io, input logic wr, input logic [15:0] a,
                              input logic [7:0] wd, input logic [7:0] zdin, input logic ge,
                              input int ntw, input logic to);
    exp_t e;
    e.wr      = wr;
    e.addr    = a;
    e.wdata   = wd;
    e.rdata   = to ? 8'hFF : zdin;
    e.claimed = io & ge;
    e.timeout = to;
    e.lat     = 1 + TDIV * (3 + int'(io) + ntw) - (to ? TDIV : 0);
    e.slow    = TDIV * (1 + int'(io) + ntw) + (to ? 0 : TDIV);
    e.oe      = wr ? e.lat - 1 : 0;
    return e;
  endfunction

  task automatic run(input logic io, input logic wr, input logic [15:0] a, input logic [7:0] wd,
                     input logic [7:0] zdin, input logic ge, input int ntw, input logic to);
    @(negedge clk);
    wait_idle();
    req_io = io; req_wr = wr; req_addr = a; req_wdata = wd;
    zd_in = zdin; ziorqge = ge; zwait_n = (ntw == 0);
    sb.push_back(mk(io, wr, a, wd, zdin, ge, ntw, to));
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    if (!to && ntw > 0) begin
      repeat (TDIV * (1 + int'(io) + ntw)) @(negedge clk);
      zwait_n = 1'b1;
    end
    wait_done();
    @(negedge clk);
    zwait_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy_done", {busy, done, claimed, timeout, zd_oe}, 5'b00000);
    chk("rst_rdata", rdata, 8'hFF);
    chk("rst_za_zd", {za, zd_out}, 24'h0);
    chk("rst_strobes", {zmreq_n, ziorq_n, zrd_n, zwr_n}, 4'hF);

    run(1'b0, 1'b0, 16'h4000, 8'h00, 8'h5A, 1'b0, 0, 1'b0);  // mem read
    run(1'b1, 1'b1, 16'h81AB, 8'hC3, 8'h00, 1'b1, 0, 1'b0);  // io write, claimed
    run(1'b1, 1'b0, 16'h00FE, 8'h00, 8'hFF, 1'b0, 0, 1'b0);  // io read, unclaimed
    run(1'b0, 1'b1, 16'h1234, 8'h77, 8'h00, 1'b0, 2, 1'b0);  // mem write, 2 waits
    run(1'b1, 1'b0, 16'h00AB, 8'h00, 8'h00, 1'b0, MAXWAIT, 1'b1);  // io timeout
    run(1'b0, 1'b0, 16'hFFFF, 8'h00, 8'hA5, 1'b1, 0, 1'b0);  // mem ignores ziorqge
    run(1'b1, 1'b0, 16'h10AB, 8'h00, 8'h81, 1'b1, 1, 1'b0);  // io read, 1 wait

    // Reset in the middle of an I/O wait state: no done, bus released.
    @(negedge clk);
    wait_idle();
    req_io = 1'b1; req_wr = 1'b0; req_addr = 16'h20AB; zwait_n = 1'b0; ziorqge = 1'b0;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_strobes", {zmreq_n, ziorq_n, zrd_n, zwr_n}, 4'hF);
    chk("midrst_oe_busy_done", {zd_oe, busy, done}, 3'b000);
    repeat (20) @(negedge clk);
    zwait_n = 1'b1;
    run(1'b1, 1'b0, 16'h30AB, 8'h00, 8'h3C, 1'b1, 0, 1'b0);

    // req held high: ignored while busy, restarts a cycle after done.
    @(negedge clk);
    wait_idle();
    req_io = 1'b0; req_wr = 1'b0; req_addr = 16'h5555; zd_in = 8'h96; ziorqge = 1'b0;
    sb.push_back(mk(1'b0, 1'b0, 16'h5555, 8'h00, 8'h96, 1'b0, 0, 1'b0));
    sb.push_back(mk(1'b0, 1'b0, 16'h5555, 8'h00, 8'h96, 1'b0, 0, 1'b0));
    req = 1'b1;
    @(negedge clk);
    wait_done();
    repeat (2) @(negedge clk);
    req = 1'b0;
    wait_done();
    @(negedge clk);
    wait_idle();
    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
